mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline. Consumes the EX-stage result bundle:
//  wd, wreg, wdata, aluop, mem_addr, reg2, pc. Drives the data-memory bus for
//  LB/LH/LW/SB/SH/SW using a req/ack handshake, byte-lane steering and load
//  sign extension. Registers the write-back bundle into WB. Raises stallreq_o
//  while a bus access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  ACCESS cycles without ack before the access is aborted (1..255)
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          reset, synchronous, active-low
//  wd_i          in   5          EX dest register number
//  wreg_i        in   1          EX dest write enable
//  wdata_i       in   32         EX ALU result
//  aluop_i       in   `AluOpBus  EX operation code (ALU_OP_*)
//  mem_addr_i    in   32         effective byte address
//  reg2_i        in   32         store data source
//  pc_i          in   32         instruction PC
//  data_req_o    out  1          bus request, held until ack/abort
//  data_we_o     out  1          1 = store
//  data_be_o     out  4          byte enables, bit k = bits [8k+7:8k]
//  data_addr_o   out  32         word address {addr[31:2],2'b00}
//  data_wdata_o  out  32         lane-replicated store data
//  data_rdata_i  in   32         read data, valid with ack
//  data_ack_i    in   1          one-cycle completion pulse
//  wd_o/wreg_o/wdata_o out 5/1/32  registered write-back bundle
//  pc_o          out  32         registered PC of the retiring instruction
//  stallreq_o    out  1          combinational pipeline stall request
//  align_err_o   out  1          one-cycle pulse: misaligned access (AdEL/AdES)
//  bus_err_o     out  1          one-cycle pulse: bus timeout
//  bad_addr_o    out  32         faulting byte address, valid with either error pulse
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE; all outputs 0; timeout counter 0.
//  Non-memory aluop: the bundle is registered at the next edge (1-cycle latency).
//  No bus activity; stallreq_o=0.
//  Misalignment: LW/SW with addr[1:0]!=0; LH/SH with addr[0]!=0.
//  - No bus access is made.
//  - Next edge: align_err_o=1, bad_addr_o=addr, wreg_o=0.
//  FSM IDLE: on an aligned memory op:
//  - latch aluop, address, reg2, wd, wreg and pc;
//  - go to ACCESS; stallreq_o=1 this cycle; wreg_o<=0 (bubble).
//  FSM ACCESS:
//  - data_req_o=1. The address, be, we and wdata outputs stay stable until exit.
//  - stallreq_o = !data_ack_i.
//  - On ack: register the WB bundle and go to IDLE. Loads write the formatted
//    rdata with wreg_o = latched wreg; stores set wreg_o=0.
//  - Without ack: counter++. When the counter reaches TIMEOUT_CYCLES, drop req,
//    pulse bus_err_o, set bad_addr_o, wreg_o=0, stallreq_o=0, go to IDLE.
//  - While stalled, wreg_o=0 every cycle, so write-back is never duplicated.
//  The pipeline holds the EX inputs stable while stallreq_o=1.
//  Lanes (little-endian; k = addr[1:0]):
//  - SB: be=1<<k, wdata={4{reg2[7:0]}}.
//  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{reg2[15:0]}}.
//  - SW: be=4'b1111.
//  - Loads use be=4'b1111.
//  - LB: sign-extend rdata byte k.
//  - LH: sign-extend rdata half addr[1].
//  - LW: rdata as is.
//  Minimum memory op: 1 stall cycle (IDLE detect). Ack in the first ACCESS cycle
//  puts the result on wdata_o one cycle later.
//  An ack seen in IDLE is ignored. A reset during ACCESS drops req at that edge,
//  and a late ack is then ignored.
// TESTING
//  1. ALU op: addu wd=3, wreg=1, wdata=0x1234 -> next cycle wd_o=3, wreg_o=1,
//     wdata_o=0x1234, stallreq_o never 1.
//  2. Load LB at 0x1003, ack on the 1st ACCESS cycle, rdata=0x80FFFFFF:
//     - data_addr_o=0x1000, be=0xF, stall exactly 1 cycle;
//     - wdata_o=0xFFFFFF80.
//  3. Store SH at 0x2002, reg2=0xAAAA5678, ack after 3 wait cycles:
//     - be=4'b1100, wdata=0x56785678, we=1;
//     - req held 4 cycles, then wreg_o=0.
//  4. Misalignment: LW at 0x3001 -> no req; align_err_o pulse; bad_addr_o=0x3001.
//  5. Timeout: SW with no ack, TIMEOUT_CYCLES=4:
//     - req high for 4 cycles, then drops;
//     - bus_err_o pulse; stallreq_o released.
//  6. Reset in the 2nd ACCESS cycle of an LW, then ack next cycle:
//     - req=0 after the edge, all outputs 0, the ack is ignored;
//     - a following LH at 0x4002 with rdata=0x7FFF0000 returns 0x00007FFF.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the 5-stage MIPS pipeline.
// Runs LB/LH/LW/SB/SH/SW over a req/ack data bus, steers byte lanes,
// sign-extends loads and registers the write-back bundle into WB.
// Misaligned accesses and bus timeouts are reported as one-cycle pulses.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] pc_i,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_ack_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] pc_o,
  output logic        stallreq_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic [31:0] bad_addr_o
);

  localparam logic [7:0] ALU_OP_LB = 8'hE0;
  localparam logic [7:0] ALU_OP_LH = 8'hE1;
  localparam logic [7:0] ALU_OP_LW = 8'hE3;
  localparam logic [7:0] ALU_OP_SB = 8'hE8;
  localparam logic [7:0] ALU_OP_SH = 8'hE9;
  localparam logic [7:0] ALU_OP_SW = 8'hEB;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;

  // Last ACCESS cycle index before the access is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_count;
  logic [7:0]  r_aluOp;
  logic [31:0] r_addr;
  logic [31:0] r_reg2;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_pc;

  logic        w_isMem;
  logic        w_misaligned;
  logic        w_start;
  logic        w_inAccess;
  logic        w_timeoutHit;
  logic        w_accLoad;
  logic        w_accStore;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;
  logic [31:0] w_loadData;

  // Decode the incoming EX op and decide whether a bus access starts this cycle.
  always_comb begin
    w_isMem      = 1'b0;
    w_misaligned = 1'b0;
    case (aluop_i)
      ALU_OP_LB, ALU_OP_SB: w_isMem = 1'b1;
      ALU_OP_LH, ALU_OP_SH: begin
        w_isMem      = 1'b1;
        w_misaligned = mem_addr_i[0];
      end
      ALU_OP_LW, ALU_OP_SW: begin
        w_isMem      = 1'b1;
        w_misaligned = (mem_addr_i[1:0] != 2'b00);
      end
      default: ;
    endcase
    w_inAccess   = (r_state == S_ACCESS);
    w_start      = (r_state == S_IDLE) && w_isMem && !w_misaligned;
    w_timeoutHit = w_inAccess && !data_ack_i && (r_count == TIMEOUT_LAST);
    w_accLoad    = (r_aluOp == ALU_OP_LB) || (r_aluOp == ALU_OP_LH) || (r_aluOp == ALU_OP_LW);
    w_accStore   = (r_aluOp == ALU_OP_SB) || (r_aluOp == ALU_OP_SH) || (r_aluOp == ALU_OP_SW);
  end

  // Byte-lane steering of the latched store; loads always read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_reg2;
    case (r_aluOp)
      ALU_OP_SB: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_reg2[7:0]}};
      end
      ALU_OP_SH: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half out of the returned word and sign-extend it.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_loadByte = data_rdata_i[7:0];
      2'd1:    w_loadByte = data_rdata_i[15:8];
      2'd2:    w_loadByte = data_rdata_i[23:16];
      default: w_loadByte = data_rdata_i[31:24];
    endcase
    w_loadHalf = r_addr[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (r_aluOp)
      ALU_OP_LB: w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
      ALU_OP_LH: w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
      default:   w_loadData = data_rdata_i;
    endcase
  end

  // Bus outputs come from the latched request and are forced to zero outside ACCESS.
  assign data_req_o   = w_inAccess;
  assign data_we_o    = w_inAccess && w_accStore;
  assign data_be_o    = w_inAccess ? w_be : 4'b0000;
  assign data_addr_o  = w_inAccess ? {r_addr[31:2], 2'b00} : 32'h0;
  assign data_wdata_o = w_inAccess ? w_wdata : 32'h0;
  assign stallreq_o   = w_start || (w_inAccess && !data_ack_i && !w_timeoutHit);

  // Access FSM: latch the EX bundle on start, count wait cycles, leave on ack or timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= 8'd0;
      r_aluOp <= 8'd0;
      r_addr  <= 32'h0;
      r_reg2  <= 32'h0;
      r_wd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_pc    <= 32'h0;
    end else if (w_start) begin
      r_state <= S_ACCESS;
      r_count <= 8'd0;
      r_aluOp <= aluop_i;
      r_addr  <= mem_addr_i;
      r_reg2  <= reg2_i;
      r_wd    <= wd_i;
      r_wreg  <= wreg_i;
      r_pc    <= pc_i;
    end else if (w_inAccess) begin
      if (data_ack_i || w_timeoutHit) begin
        r_state <= S_IDLE;
      end else begin
        r_count <= r_count + 8'd1;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end

  // Write-back bundle and error pulses; wreg_o is held low for every stalled cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= 32'h0;
      pc_o        <= 32'h0;
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
      bad_addr_o  <= 32'h0;
    end else begin
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
      if (w_inAccess) begin
        if (data_ack_i) begin
          wd_o    <= r_wd;
          wreg_o  <= w_accLoad ? r_wreg : 1'b0;
          wdata_o <= w_accLoad ? w_loadData : 32'h0;
          pc_o    <= r_pc;
        end else if (w_timeoutHit) begin
          wreg_o     <= 1'b0;
          pc_o       <= r_pc;
          bus_err_o  <= 1'b1;
          bad_addr_o <= r_addr;
        end else begin
          wreg_o <= 1'b0;
        end
      end else if (w_isMem) begin
        wreg_o <= 1'b0;
        if (w_misaligned) begin
          wd_o        <= wd_i;
          pc_o        <= pc_i;
          align_err_o <= 1'b1;
          bad_addr_o  <= mem_addr_i;
        end
      end else begin
        wd_o    <= wd_i;
        wreg_o  <= wreg_i;
        wdata_o <= wdata_i;
        pc_o    <= pc_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven vectors, a reset-during-access sequence and
// randomized traffic checked against a byte-array memory model.
module tb_mem_access_unit;

  localparam int TIMEOUT = 4;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_LB   = 8'hE0;
  localparam logic [7:0] OP_LH   = 8'hE1;
  localparam logic [7:0] OP_LW   = 8'hE3;
  localparam logic [7:0] OP_SB   = 8'hE8;
  localparam logic [7:0] OP_SH   = 8'hE9;
  localparam logic [7:0] OP_SW   = 8'hEB;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [31:0] pc_i;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] pc_o;
  logic        stallreq_o;
  logic        align_err_o;
  logic        bus_err_o;
  logic [31:0] bad_addr_o;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    int          reqCycles;
    int          stallCycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] busWdata;
    logic        wreg;
    logic [31:0] wdata;
    logic        alignErr;
    logic        busErr;
    logic [31:0] badAddr;
  } exp_t;

  typedef struct {
    int          reqCycles;
    int          stallCycles;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] busWdata;
    logic        stable;
    logic        done;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        alignErr;
    logic        busErr;
    logic [31:0] badAddr;
  } obs_t;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] pc;
    int          ackAfter;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .pc_i(pc_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .data_ack_i(data_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .pc_o(pc_o),
    .stallreq_o(stallreq_o), .align_err_o(align_err_o), .bus_err_o(bus_err_o),
    .bad_addr_o(bad_addr_o)
  );

  always #5 clk = ~clk;

  // Hard stop in case a wait slips past its own bound.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic driveNop();
    aluop_i = OP_NOP; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
    mem_addr_i = 32'h0; reg2_i = 32'h0; pc_i = 32'h0;
  endtask

  // Drives one EX bundle (called at posedge+1), answers the bus after ackAfter
  // wait cycles (negative = never) and records what the DUT did.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                               input logic [31:0] pc, input int ackAfter, input logic [31:0] rdata,
                               output obs_t o);
    o = '{default: '0};
    o.stable = 1'b1;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wreg;
    wdata_i = wdata; pc_i = pc; data_ack_i = 1'b0;
    for (int c = 0; c < 40 && !o.done; c++) begin
      @(negedge clk);
      if (data_req_o) begin
        if (o.reqCycles == 0) begin
          o.addr = data_addr_o; o.be = data_be_o; o.we = data_we_o; o.busWdata = data_wdata_o;
        end else if (o.addr !== data_addr_o || o.be !== data_be_o || o.we !== data_we_o ||
                     o.busWdata !== data_wdata_o) begin
          o.stable = 1'b0;
        end
        if (o.reqCycles == ackAfter) begin
          data_ack_i = 1'b1;
          data_rdata_i = rdata;
        end
        o.reqCycles++;
      end
      #1;
      if (stallreq_o) o.stallCycles++;
      else o.done = 1'b1;
      @(posedge clk);
      #1;
      data_ack_i = 1'b0;
      data_rdata_i = 32'h0;
    end
    driveNop();
    @(negedge clk);
    o.wd = wd_o; o.wreg = wreg_o; o.wdata = wdata_o; o.pc = pc_o;
    o.alignErr = align_err_o; o.busErr = bus_err_o; o.badAddr = bad_addr_o;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the access rules: sizes, lanes, sign extension, timeout.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                 input logic wreg, input logic [31:0] wdata, input int ackAfter,
                                 input logic [31:0] rdata);
    exp_t e;
    int size, lane;
    logic isStore, timedOut;
    longint mask, value;
    e = '{default: '0};
    size = (op == OP_LB || op == OP_SB) ? 1 : (op == OP_LH || op == OP_SH) ? 2 :
           (op == OP_LW || op == OP_SW) ? 4 : 0;
    if (size == 0) begin
      e.wreg = wreg; e.wdata = wdata;
      return e;
    end
    if (addr % size != 0) begin
      e.alignErr = 1'b1; e.badAddr = addr;
      return e;
    end
    isStore = (op == OP_SB || op == OP_SH || op == OP_SW);
    timedOut = (ackAfter < 0) || (ackAfter >= TIMEOUT);
    e.reqCycles = timedOut ? TIMEOUT : ackAfter + 1;
    e.stallCycles = e.reqCycles;
    lane = addr % 4;
    e.addr = addr - lane;
    mask = (64'd1 << (8 * size)) - 1;
    e.be = isStore ? 4'(((1 << size) - 1) << lane) : 4'hF;
    e.we = isStore;
    if (isStore) begin
      value = longint'(reg2) & mask;
      for (int k = 0; k < 4; k += size) e.busWdata = e.busWdata | 32'(value << (8 * k));
    end
    if (timedOut) begin
      e.busErr = 1'b1; e.badAddr = addr;
    end else if (!isStore) begin
      value = (longint'(rdata) >> (8 * lane)) & mask;
      if (value[8 * size - 1]) value = value | ~mask;
      e.wreg = wreg; e.wdata = 32'(value);
    end
    return e;
  endfunction

  task automatic compareAll(input string tag, input obs_t o, input exp_t e,
                            input logic [4:0] wd, input logic [31:0] pc);
    checkOutput({tag, " done"}, 32'(o.done), 32'd1);
    checkOutput({tag, " reqCycles"}, 32'(o.reqCycles), 32'(e.reqCycles));
    checkOutput({tag, " stallCycles"}, 32'(o.stallCycles), 32'(e.stallCycles));
    if (e.reqCycles > 0) begin
      checkOutput({tag, " addr"}, o.addr, e.addr);
      checkOutput({tag, " be"}, 32'(o.be), 32'(e.be));
      checkOutput({tag, " we"}, 32'(o.we), 32'(e.we));
      checkOutput({tag, " busStable"}, 32'(o.stable), 32'd1);
      if (e.we) checkOutput({tag, " busWdata"}, o.busWdata, e.busWdata);
    end
    checkOutput({tag, " wreg"}, 32'(o.wreg), 32'(e.wreg));
    if (e.wreg) begin
      checkOutput({tag, " wd"}, 32'(o.wd), 32'(wd));
      checkOutput({tag, " wdata"}, o.wdata, e.wdata);
    end
    checkOutput({tag, " pc"}, o.pc, pc);
    checkOutput({tag, " alignErr"}, 32'(o.alignErr), 32'(e.alignErr));
    checkOutput({tag, " busErr"}, 32'(o.busErr), 32'(e.busErr));
    if (e.alignErr || e.busErr) checkOutput({tag, " badAddr"}, o.badAddr, e.badAddr);
  endtask

  vec_t vecs[12];
  logic [7:0] memBytes[64];

  initial begin
    obs_t o;
    exp_t e;
    logic [7:0] op;
    logic [31:0] addr, reg2, rdata, pc;
    logic [4:0] wd;
    logic wreg;
    int ackAfter, size, base;
    logic [7:0] opTable[7];

    vecs[0]  = '{"addu",      OP_ADDU, 32'h0,    32'h0,        5'd3,  1'b1, 32'h1234, 32'h100, -1, 32'h0,
                 '{0, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b0, 1'b0, 32'h0}};
    vecs[1]  = '{"lb1003",    OP_LB,   32'h1003, 32'h0,        5'd5,  1'b1, 32'h0, 32'h104, 0, 32'h80FFFFFF,
                 '{1, 1, 32'h1000, 4'hF, 1'b0, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0}};
    vecs[2]  = '{"sh2002",    OP_SH,   32'h2002, 32'hAAAA5678, 5'd6,  1'b1, 32'h0, 32'h108, 3, 32'h0,
                 '{4, 4, 32'h2000, 4'hC, 1'b1, 32'h56785678, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}};
    vecs[3]  = '{"lwMisalign", OP_LW,  32'h3001, 32'h0,        5'd7,  1'b1, 32'h0, 32'h10C, 0, 32'h0,
                 '{0, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3001}};
    vecs[4]  = '{"swTimeout", OP_SW,   32'h5000, 32'hDEADBEEF, 5'd8,  1'b1, 32'h0, 32'h110, -1, 32'h0,
                 '{4, 4, 32'h5000, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5000}};
    vecs[5]  = '{"lh4002",    OP_LH,   32'h4002, 32'h0,        5'd9,  1'b1, 32'h0, 32'h114, 1, 32'h7FFF0000,
                 '{2, 2, 32'h4000, 4'hF, 1'b0, 32'h0, 1'b1, 32'h00007FFF, 1'b0, 1'b0, 32'h0}};
    vecs[6]  = '{"sb1001",    OP_SB,   32'h1001, 32'h12345678, 5'd10, 1'b1, 32'h0, 32'h118, 0, 32'h0,
                 '{1, 1, 32'h1000, 4'b0010, 1'b1, 32'h78787878, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}};
    vecs[7]  = '{"lh0000",    OP_LH,   32'h0,    32'h0,        5'd11, 1'b1, 32'h0, 32'h11C, 2, 32'h12348001,
                 '{3, 3, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, 32'h0}};
    vecs[8]  = '{"shMisalign", OP_SH,  32'h2001, 32'h1111,     5'd12, 1'b1, 32'h0, 32'h120, 0, 32'h0,
                 '{0, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2001}};
    vecs[9]  = '{"lb0011",    OP_LB,   32'h11,   32'h0,        5'd13, 1'b1, 32'h0, 32'h124, 0, 32'h00007F00,
                 '{1, 1, 32'h10, 4'hF, 1'b0, 32'h0, 1'b1, 32'h0000007F, 1'b0, 1'b0, 32'h0}};
    vecs[10] = '{"lw0020",    OP_LW,   32'h20,   32'h0,        5'd14, 1'b1, 32'h0, 32'h128, 1, 32'hCAFEF00D,
                 '{2, 2, 32'h20, 4'hF, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0}};
    vecs[11] = '{"sb1003",    OP_SB,   32'h1003, 32'h000000AB, 5'd15, 1'b1, 32'h0, 32'h12C, 0, 32'h0,
                 '{1, 1, 32'h1000, 4'b1000, 1'b1, 32'hABABABAB, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}};

    // Reset with a quiet pipeline: every output must be zero.
    rst = 1'b0;
    data_ack_i = 1'b0;
    data_rdata_i = 32'h0;
    driveNop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req", 32'(data_req_o), 32'd0);
    checkOutput("reset stall", 32'(stallreq_o), 32'd0);
    checkOutput("reset wreg", 32'(wreg_o), 32'd0);
    checkOutput("reset wdata", wdata_o, 32'h0);
    checkOutput("reset errs", {30'd0, align_err_o, bus_err_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].wd, vecs[i].wreg,
                    vecs[i].wdata, vecs[i].pc, vecs[i].ackAfter, vecs[i].rdata, o);
      compareAll(vecs[i].name, o, vecs[i].e, vecs[i].wd, vecs[i].pc);
    end

    // Reset in the 2nd ACCESS cycle of an LW, then a stray ack one cycle later.
    aluop_i = OP_LW; mem_addr_i = 32'h4000; wd_i = 5'd7; wreg_i = 1'b1; pc_i = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    driveNop();
    @(negedge clk);
    checkOutput("rstSeq reqBeforeReset", 32'(data_req_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    data_ack_i = 1'b1;
    data_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("rstSeq req", 32'(data_req_o), 32'd0);
    checkOutput("rstSeq stall", 32'(stallreq_o), 32'd0);
    checkOutput("rstSeq bus", {data_addr_o[31:4], data_be_o}, 32'd0);
    checkOutput("rstSeq wreg", 32'(wreg_o), 32'd0);
    checkOutput("rstSeq pc", pc_o, 32'h0);
    @(posedge clk); #1;
    data_ack_i = 1'b0;
    data_rdata_i = 32'h0;
    @(negedge clk);
    checkOutput("rstSeq lateAck wreg", 32'(wreg_o), 32'd0);
    checkOutput("rstSeq lateAck wdata", wdata_o, 32'h0);
    @(posedge clk); #1;
    applyStimulus(OP_LH, 32'h4002, 32'h0, 5'd4, 1'b1, 32'h0, 32'h204, 0, 32'h7FFF0000, o);
    e = model(OP_LH, 32'h4002, 32'h0, 1'b1, 32'h0, 0, 32'h7FFF0000);
    compareAll("rstSeq lh", o, e, 5'd4, 32'h204);

    // Randomized traffic against a byte-addressed memory at 0x5000..0x503F.
    opTable = '{OP_ADDU, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW};
    for (int i = 0; i < 64; i++) memBytes[i] = 8'($urandom);
    for (int n = 0; n < 60; n++) begin
      op = opTable[$urandom_range(0, 6)];
      size = (op == OP_LB || op == OP_SB) ? 1 : (op == OP_LH || op == OP_SH) ? 2 : 4;
      base = $urandom_range(0, 63);
      if ($urandom_range(0, 4) != 0) base = base - (base % size);
      addr = 32'h5000 + 32'(base);
      reg2 = $urandom;
      wd = 5'($urandom);
      wreg = 1'($urandom);
      pc = $urandom;
      ackAfter = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 2);
      rdata = {memBytes[(base & ~3) + 3], memBytes[(base & ~3) + 2],
               memBytes[(base & ~3) + 1], memBytes[base & ~3]};
      e = model(op, addr, reg2, wreg, wdata_i ^ 32'($urandom), ackAfter, rdata);
      applyStimulus(op, addr, reg2, wd, wreg, e.wdata, pc, ackAfter, rdata, o);
      compareAll($sformatf("rand%0d", n), o, e, wd, pc);
      if (e.we && !e.busErr)
        for (int k = 0; k < size; k++) memBytes[base + k] = 8'(reg2 >> (8 * k));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
